store_buffer_lsu: RTL and testbench
===================================

// Module: store_buffer_lsu
// PURPOSE
//  CPU-side initiator for the single-port data memory. Accepts load/store requests from the
//  MEM stage, queues stores in a FIFO and drains them one per cycle as mem_store_type
//  commands. Issues loads on the same address port and returns size-extracted,
//  sign/zero-extended data. Stalls a load whose dword index matches any queued store.
// PARAMETERS
//  DEPTH     4  store FIFO entries (power of 2, >=2)
//  INDEX_HI  8  top addr bit used by memory indexing; conflict compare uses addr[INDEX_HI:3]
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  reset           in   1   asynchronous, active-high; clears all state
//  req_valid       in   1   request present
//  req_ready       out  1   request accepted this cycle when req_valid & req_ready
//  req_is_load     in   1   1=load, 0=store
//  req_size        in   2   mem_size_t: SIZE_BYTE/SIZE_WORD/SIZE_DWORD
//  req_signed      in   1   load sign-extend (ignored for stores and SIZE_DWORD)
//  req_addr        in   64  byte address
//  req_wdata       in   64  store data, right-justified
//  load_valid      out  1   one-cycle pulse: load_data valid
//  load_data       out  64  extended load result
//  align_err       out  1   one-cycle pulse: misaligned request was consumed and dropped
//  flush           in   1   level; while high, no new requests accepted
//  buf_empty       out  1   FIFO empty
//  mem_addr        out  64  to data memory addr
//  mem_data_in     out  64  to data memory data_in
//  mem_store_type  out  mem_store_type_t  to data memory
//  mem_data_out    in   64  from data memory (combinational read of mem_addr)
// BEHAVIOUR
//  Reset: FIFO empty, head=tail=count=0, load_valid=0, load_data=0, align_err=0,
//   mem_store_type=NO_STORE, mem_addr=0, mem_data_in=0, buf_empty=1.
//   Assertion mid-drain discards all queued stores.
//  Alignment: WORD requires addr[1:0]==0; DWORD requires addr[2:0]==0. A misaligned request
//   is accepted (req_ready=1), raises align_err the next cycle, and neither queues nor loads.
//  Store accept: req_ready = !flush & (count<DEPTH). No same-cycle enqueue-at-full bypass.
//   Entry holds {addr, wdata, size}.
//  Load conflict: if any valid entry has addr[INDEX_HI:3] == req_addr[INDEX_HI:3],
//   req_ready=0 until the entry drains. A load never bypasses or forwards from a queued store.
//  Port arbitration: an accepted (aligned, non-conflicting) load owns mem_addr this cycle:
//   mem_addr=req_addr, mem_store_type=NO_STORE. The drain pauses. Otherwise, if the FIFO is
//   non-empty, the head drives mem_addr/mem_data_in with mem_store_type =
//   STORE_BYTE/STORE_WORD/STORE_DWORD, and the head pops on that posedge (memory writes on
//   the preceding negedge).
//  Otherwise: mem_store_type=NO_STORE and mem_addr holds req_addr.
//  Load latency is 1: on the accept posedge, load_data <= extract(mem_data_out, addr[2:0],
//   size, signed) and load_valid <= 1. load_data holds until the next load.
//  Extract: BYTE = byte addr[2:0]; WORD = addr[2] ? [63:32] : [31:0]; DWORD = all 64 bits.
//   Bit 7/31 is replicated if signed, zeros otherwise.
//  Simultaneous enqueue + drain: count unchanged. Pointers wrap mod DEPTH.
//  flush: requests are blocked; drain continues; buf_empty rises when count reaches 0.
// STRUCTURE
//  structures pkg: add typedef enum logic[1:0] mem_size_t {SIZE_BYTE, SIZE_WORD,
//   SIZE_DWORD}. Reuse mem_store_type_t and its values.
//  Sub-module load_align (combinational): mem_data_out, offset[2:0], size, signed -> 64b
//   result.
//  FIFO and conflict comparators stay inline. Entry valid bits are derived from head/count.
// TESTING
//  1 Reset, then SD 0x40 data 0x1122334455667788 -> next cycle STORE_DWORD @0x40; buf_empty=1
//    after drain.
//  2 Enqueue 4 stores back-to-back with drain blocked by loads -> req_ready=0 on the 5th;
//    wraps correctly after drain.
//  3 SB 0x41 0xAB, then LB 0x48 (different index) -> load is not stalled, drain pauses one
//    cycle; LB 0x41 -> stalled until drained, then load_data=0xFFFFFFFFFFFFFFAB
//    (0xAB zero-extended if unsigned).
//  4 LW 0x44 with word 0x80000001 in upper half -> signed 0xFFFFFFFF80000001, unsigned
//    0x0000000080000001.
//  5 SW 0x42 -> align_err pulse, FIFO unchanged, no store issued.
//  6 Three stores queued, flush=1, reset mid-drain -> all outputs at reset values; no
//    further mem_store_type!=NO_STORE.

Source files
------------

// File: rtl/store_buffer_lsu_pkg.sv
// ============================================================================
// store_buffer_lsu_pkg: shared memory-access types for the LSU. Rev 1.0
// ============================================================================
`default_nettype none

package store_buffer_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_WORD  = 2'd1,
    SIZE_DWORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    NO_STORE    = 2'd0,
    STORE_BYTE  = 2'd1,
    STORE_WORD  = 2'd2,
    STORE_DWORD = 2'd3
  } mem_store_type_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_WORD: return offset[1:0] != 2'b00;
      default:   return offset != 3'b000;
    endcase
  endfunction

  function automatic mem_store_type_t size_to_store(input mem_size_t size);
    case (size)
      SIZE_BYTE: return STORE_BYTE;
      SIZE_WORD: return STORE_WORD;
      default:   return STORE_DWORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_lsu_load_align.sv
// ============================================================================
// store_buffer_lsu_load_align: size extraction and sign/zero extension. Rev 1.0
// ============================================================================
`default_nettype none

module store_buffer_lsu_load_align
  import store_buffer_lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  mem_size_t   size,
  input  logic        is_signed,
  output logic [63:0] result
);

  logic [7:0]  byte_sel;
  logic [31:0] word_sel;

  always_comb begin
    byte_sel = data[{offset, 3'b000} +: 8];
    word_sel = offset[2] ? data[63:32] : data[31:0];
    case (size)
      SIZE_BYTE: result = {{56{is_signed & byte_sel[7]}}, byte_sel};
      SIZE_WORD: result = {{32{is_signed & word_sel[31]}}, word_sel};
      default:   result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer_lsu.sv
// ============================================================================
// store_buffer_lsu: store FIFO + load port initiator for the data memory. Rev 1.0
// ============================================================================
`default_nettype none

module store_buffer_lsu
  import store_buffer_lsu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int INDEX_HI = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  mem_size_t       req_size,
  input  logic            req_signed,
  input  logic [63:0]     req_addr,
  input  logic [63:0]     req_wdata,
  output logic            load_valid,
  output logic [63:0]     load_data,
  output logic            align_err,
  input  logic            flush,
  output logic            buf_empty,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_data_in,
  output mem_store_type_t mem_store_type,
  input  logic [63:0]     mem_data_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [63:0] ent_addr  [DEPTH];
  logic [63:0] ent_wdata [DEPTH];
  mem_size_t   ent_size  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_match;
  logic             misaligned;
  logic             conflict;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             load_go;
  logic             push;
  logic             pop;
  logic [63:0]      load_result;

  // Entry i is live when its distance from head is below count.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [PTR_W-1:0] rel;
      assign rel          = PTR_W'(i) - head;
      assign ent_valid[i] = {1'b0, rel} < count;
      assign ent_match[i] = ent_valid[i] &
                            (ent_addr[i][INDEX_HI:3] == req_addr[INDEX_HI:3]);
    end
  endgenerate

  assign misaligned = is_misaligned(req_size, req_addr[2:0]);
  assign conflict   = |ent_match;
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);
  assign buf_empty  = fifo_empty;

  always_comb begin
    req_ready = 1'b0;
    if (!reset && !flush) begin
      if (misaligned)       req_ready = 1'b1;
      else if (req_is_load) req_ready = !conflict;
      else                  req_ready = !fifo_full;
    end
  end

  assign accept  = req_valid & req_ready;
  assign load_go = accept & req_is_load & ~misaligned;
  assign push    = accept & ~req_is_load & ~misaligned;
  assign pop     = ~load_go & ~fifo_empty;

  // An accepted load owns the address port; otherwise the head drains.
  always_comb begin
    mem_addr       = req_addr;
    mem_data_in    = '0;
    mem_store_type = NO_STORE;
    if (reset) begin
      mem_addr = '0;
    end else if (pop) begin
      mem_addr       = ent_addr[head];
      mem_data_in    = ent_wdata[head];
      mem_store_type = size_to_store(ent_size[head]);
    end
  end

  store_buffer_lsu_load_align u_load_align (
    .data      (mem_data_out),
    .offset    (req_addr[2:0]),
    .size      (req_size),
    .is_signed (req_signed),
    .result    (load_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      align_err  <= 1'b0;
    end else begin
      load_valid <= load_go;
      align_err  <= accept & misaligned;
      if (load_go) load_data <= load_result;
      if (push)    tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail]  <= req_addr;
      ent_wdata[tail] <= req_wdata;
      ent_size[tail]  <= req_size;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer_lsu.sv
// ============================================================================
// tb_store_buffer_lsu: directed + random bench against a byte-level LSU model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer_lsu;
  import store_buffer_lsu_pkg::*;

  localparam int DEPTH = 4;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_is_load;
  mem_size_t       req_size;
  logic            req_signed;
  logic [63:0]     req_addr;
  logic [63:0]     req_wdata;
  logic            load_valid;
  logic [63:0]     load_data;
  logic            align_err;
  logic            flush;
  logic            buf_empty;
  logic [63:0]     mem_addr;
  logic [63:0]     mem_data_in;
  mem_store_type_t mem_store_type;
  logic [63:0]     mem_data_out;

  store_buffer_lsu #(.DEPTH(DEPTH), .INDEX_HI(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_load    (req_is_load),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .align_err      (align_err),
    .flush          (flush),
    .buf_empty      (buf_empty),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_store_type (mem_store_type),
    .mem_data_out   (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical data memory seen by the DUT: combinational read, negedge write.
  logic [63:0] pmem [0:63];
  logic [7:0]  ref_mem [0:511];
  logic        mem_load;
  assign mem_data_out = pmem[mem_addr[8:3]];

  always @(negedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++)
        for (int k = 0; k < 8; k++)
          pmem[i][8*k +: 8] <= ref_mem[8*i + k];
    end else begin
      case (mem_store_type)
        STORE_BYTE:  pmem[mem_addr[8:3]][{mem_addr[2:0], 3'b000} +: 8] <= mem_data_in[7:0];
        STORE_WORD:  pmem[mem_addr[8:3]][{mem_addr[2], 5'b00000} +: 32] <= mem_data_in[31:0];
        STORE_DWORD: pmem[mem_addr[8:3]] <= mem_data_in;
        default: ;
      endcase
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    mem_size_t   sz;
  } ent_t;

  ent_t        q[$];
  logic        in_reset, chk_en;
  logic        e_ready, e_empty, e_lv, e_ae;
  logic [1:0]  e_type;
  logic [63:0] e_addr, e_din, e_ld;
  logic        m_accept, m_load, m_drain, m_mis, m_ld, m_sg;
  mem_size_t   m_sz;
  logic [63:0] m_a, m_d;

  function automatic int nbytes(input mem_size_t sz);
    return (sz == SIZE_BYTE) ? 1 : (sz == SIZE_WORD) ? 4 : 8;
  endfunction

  function automatic logic misal(input mem_size_t sz, input logic [63:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input mem_size_t sz, input logic sg);
    logic [63:0] v;
    int n, base;
    n = nbytes(sz);
    base = int'(a[8:0]);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(ref_mem[base + k]) << (8*k));
    if (sg && n < 8 && v[8*n - 1]) v = v | ((~64'd0) << (8*n));
    return v;
  endfunction

  task automatic drive(input logic v, input logic ld, input mem_size_t sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] d, input logic fl);
    logic conf;
    req_valid = v; req_is_load = ld; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d; flush = fl;
    m_ld = ld; m_sz = sz; m_sg = sg; m_a = a; m_d = d;
    m_mis = misal(sz, a);
    conf = 1'b0;
    foreach (q[i]) if (q[i].a[8:3] == a[8:3]) conf = 1'b1;
    e_ready  = !fl && (m_mis || (ld ? !conf : (q.size() < DEPTH)));
    m_accept = v && e_ready && !in_reset;
    m_load   = m_accept && ld && !m_mis;
    m_drain  = !in_reset && !m_load && (q.size() > 0);
    e_empty  = (q.size() == 0);
    e_type   = 2'(NO_STORE);
    e_addr   = a;
    e_din    = '0;
    if (m_drain) begin
      e_type = (q[0].sz == SIZE_BYTE) ? 2'(STORE_BYTE) :
               (q[0].sz == SIZE_WORD) ? 2'(STORE_WORD) : 2'(STORE_DWORD);
      e_addr = q[0].a;
      e_din  = q[0].d;
    end
  endtask

  task automatic finish_cycle();
    @(negedge clk);
    @(posedge clk);
    if (!in_reset) begin
      e_lv = m_load;
      e_ae = m_accept && m_mis;
      if (m_load) e_ld = ref_load(m_a, m_sz, m_sg);
      if (m_drain) begin
        for (int k = 0; k < nbytes(q[0].sz); k++)
          ref_mem[int'(q[0].a[8:0]) + k] = q[0].d[8*k +: 8];
        void'(q.pop_front());
      end
      if (m_accept && !m_ld && !m_mis) q.push_back('{a: m_a, d: m_d, sz: m_sz});
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, SIZE_BYTE, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    in_reset = 1'b1;
    q.delete();
    e_lv = 1'b0; e_ae = 1'b0; e_ld = '0;
    m_accept = 1'b0; m_load = 1'b0; m_drain = 1'b0;
  endtask

  // Single compare process: all DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (in_reset) begin
        chk("rst_store_type", 64'(mem_store_type), 64'(NO_STORE));
        chk("rst_mem_addr",   mem_addr,    64'd0);
        chk("rst_mem_data_in", mem_data_in, 64'd0);
        chk("rst_buf_empty",  64'(buf_empty),  64'd1);
        chk("rst_load_valid", 64'(load_valid), 64'd0);
        chk("rst_align_err",  64'(align_err),  64'd0);
        chk("rst_load_data",  load_data,   64'd0);
      end else begin
        chk("req_ready",  64'(req_ready), 64'(e_ready));
        chk("store_type", 64'(mem_store_type), 64'(e_type));
        chk("mem_addr",   mem_addr, e_addr);
        if (e_type != 2'(NO_STORE)) chk("mem_data_in", mem_data_in, e_din);
        chk("buf_empty",  64'(buf_empty),  64'(e_empty));
        chk("load_valid", 64'(load_valid), 64'(e_lv));
        chk("align_err",  64'(align_err),  64'(e_ae));
        chk("load_data",  load_data, e_ld);
      end
    end
  end

  logic [63:0] ra;
  mem_size_t   rsz;

  initial begin
    reset = 1'b1; in_reset = 1'b1; chk_en = 1'b0;
    e_lv = 1'b0; e_ae = 1'b0; e_ld = '0;
    req_valid = 1'b0; req_is_load = 1'b0; req_size = SIZE_BYTE; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; flush = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
    mem_load = 1'b1;

    @(posedge clk); #1;
    chk_en = 1'b1;
    idle();
    #1 chk("lit_reset_empty", 64'(buf_empty), 64'd1);
    chk("lit_reset_ld", load_data, 64'd0);
    finish_cycle();
    idle();
    finish_cycle();
    mem_load = 1'b0;
    reset = 1'b0; in_reset = 1'b0;
    idle(); finish_cycle();

    // SD 0x40 then drain
    drive(1'b1, 1'b0, SIZE_DWORD, 1'b0, 64'h40, 64'h1122334455667788, 1'b0);
    #1 chk("lit_t1_ready", 64'(req_ready), 64'd1);
    finish_cycle();
    idle();
    #1 chk("lit_t1_type", 64'(mem_store_type), 64'(STORE_DWORD));
    chk("lit_t1_addr", mem_addr, 64'h40);
    chk("lit_t1_din", mem_data_in, 64'h1122334455667788);
    chk("lit_t1_busy", 64'(buf_empty), 64'd0);
    finish_cycle();
    idle();
    #1 chk("lit_t1_empty", 64'(buf_empty), 64'd1);
    finish_cycle();

    // Back-to-back stores walk the pointers around the ring
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, SIZE_BYTE, 1'b0, 64'h100 + 64'(i), 64'(i) + 64'h50, 1'b0);
      finish_cycle();
    end
    drive(1'b1, 1'b0, SIZE_BYTE, 1'b0, 64'h108, 64'h77, 1'b1);
    #1 chk("lit_t2_flush_block", 64'(req_ready), 64'd0);
    finish_cycle();
    idle(); finish_cycle();
    drive(1'b1, 1'b1, SIZE_BYTE, 1'b0, 64'h105, 64'd0, 1'b0);
    finish_cycle();
    chk("lit_t2_wrap_ld", load_data, 64'h55);

    // Non-conflicting load pauses drain; conflicting load stalls
    drive(1'b1, 1'b0, SIZE_BYTE, 1'b0, 64'h41, 64'hAB, 1'b0);
    finish_cycle();
    drive(1'b1, 1'b1, SIZE_BYTE, 1'b1, 64'h48, 64'd0, 1'b0);
    #1 chk("lit_t3_nc_ready", 64'(req_ready), 64'd1);
    chk("lit_t3_pause", 64'(mem_store_type), 64'(NO_STORE));
    chk("lit_t3_ld_addr", mem_addr, 64'h48);
    finish_cycle();
    drive(1'b1, 1'b1, SIZE_BYTE, 1'b1, 64'h41, 64'd0, 1'b0);
    #1 chk("lit_t3_stall", 64'(req_ready), 64'd0);
    chk("lit_t3_drain", 64'(mem_store_type), 64'(STORE_BYTE));
    finish_cycle();
    drive(1'b1, 1'b1, SIZE_BYTE, 1'b1, 64'h41, 64'd0, 1'b0);
    #1 chk("lit_t3_go", 64'(req_ready), 64'd1);
    finish_cycle();
    chk("lit_t3_lv", 64'(load_valid), 64'd1);
    chk("lit_t3_lb", load_data, 64'hFFFFFFFFFFFFFFAB);
    drive(1'b1, 1'b1, SIZE_BYTE, 1'b0, 64'h41, 64'd0, 1'b0);
    finish_cycle();
    chk("lit_t3_lbu", load_data, 64'h00000000000000AB);

    // Word in upper half, signed vs unsigned
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 64'h44, 64'h80000001, 1'b0);
    finish_cycle();
    idle(); finish_cycle();
    drive(1'b1, 1'b1, SIZE_WORD, 1'b1, 64'h44, 64'd0, 1'b0);
    finish_cycle();
    chk("lit_t4_lw", load_data, 64'hFFFFFFFF80000001);
    drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 64'h44, 64'd0, 1'b0);
    finish_cycle();
    chk("lit_t4_lwu", load_data, 64'h0000000080000001);

    // Misaligned store
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 64'h42, 64'h1234, 1'b0);
    #1 chk("lit_t5_ready", 64'(req_ready), 64'd1);
    finish_cycle();
    chk("lit_t5_err", 64'(align_err), 64'd1);
    chk("lit_t5_empty", 64'(buf_empty), 64'd1);
    idle();
    #1 chk("lit_t5_nostore", 64'(mem_store_type), 64'(NO_STORE));
    finish_cycle();

    // Reset in the middle of a drain under flush
    drive(1'b1, 1'b0, SIZE_DWORD, 1'b0, 64'h80, 64'hDEADBEEFCAFEF00D, 1'b0);
    finish_cycle();
    drive(1'b1, 1'b0, SIZE_DWORD, 1'b0, 64'h88, 64'h1, 1'b1);
    #1 chk("lit_t6_draining", 64'(mem_store_type), 64'(STORE_DWORD));
    assert_reset();
    #1 chk("lit_t6_rst_type", 64'(mem_store_type), 64'(NO_STORE));
    chk("lit_t6_rst_addr", mem_addr, 64'd0);
    chk("lit_t6_rst_empty", 64'(buf_empty), 64'd1);
    finish_cycle();
    idle(); finish_cycle();
    reset = 1'b0; in_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(); finish_cycle();
    end
    drive(1'b1, 1'b1, SIZE_DWORD, 1'b0, 64'h80, 64'd0, 1'b0);
    finish_cycle();

    // Random traffic with a narrow index range to provoke conflicts
    for (int n = 0; n < 1500; n++) begin
      rsz = mem_size_t'($urandom_range(0, 2));
      ra  = {($urandom_range(0, 3) == 0) ? 55'($urandom) : 55'd0,
             6'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 99) < 85) begin
        if (rsz == SIZE_WORD)  ra[1:0] = 2'b00;
        if (rsz == SIZE_DWORD) ra[2:0] = 3'b000;
      end
      drive(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), rsz,
            1'($urandom_range(0, 1)), ra, {$urandom, $urandom},
            1'($urandom_range(0, 9) == 0));
      finish_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); finish_cycle();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
